mem_burst_req_gen: RTL and testbench

- Upstream request generator for the stream-to-memory adapter.
- Accepts one burst command (base address, beat count, read/write) and emits one word request per beat on a valid/ready stream, with incrementing addresses.
- For writes, it pairs each beat with one word from a write-data stream.
- It counts completed response handshakes and pulses done_o when the last response of the burst has been consumed.

---
 rtl/mem_burst_req_gen.sv | 171 +++++++++++++++++
 tb/tb_mem_burst_req_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_req_gen.sv
// Burst request generator for the stream-to-memory adapter.
//
// Accepts one burst command (base address, beats-1, read/write). It emits one word request per
// beat on a valid/ready stream, with addresses incrementing by BeatBytes. Write bursts pair each
// beat with one word from the write-data stream. Response handshakes are counted, and done_o
// pulses once after the last response of the burst has been consumed.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_*                 burst command (addr, len = beats-1, write) with valid/ready
//   wdata_*               write-data stream (consumed only on request handshake)
//   req_*                 outgoing word requests (addr, we, wdata) with valid/ready
//   rsp_hs_i              one downstream response handshake this cycle
//   busy_o                burst in progress
//   done_o                one-cycle pulse after the final response
module mem_burst_req_gen #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned BeatBytes = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 cmd_write_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic                 req_we_o,
  output logic [DataWidth-1:0] req_wdata_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  input  logic                 rsp_hs_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned BeatShift = $clog2(BeatBytes);
  // One extra bit so a full 2^LenWidth-beat burst is countable.
  localparam int unsigned CntWidth  = LenWidth + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic                 write_q, write_d;
  logic [CntWidth-1:0]  iss_q, iss_d;
  logic [CntWidth-1:0]  rsp_q, rsp_d;
  logic                 done_q, done_d;

  logic [CntWidth-1:0]  rsp_next;
  logic [CntWidth-1:0]  beats;
  logic                 all_rsp;
  logic [AddrWidth-1:0] offset;
  logic                 req_hs;

  // Responses may land in the same cycle as their request, so completion includes rsp_hs_i.
  assign rsp_next = rsp_q + CntWidth'(rsp_hs_i);
  assign beats    = CntWidth'(len_q) + CntWidth'(1);
  assign all_rsp  = (rsp_next == beats);
  // Address arithmetic wraps silently at the top of the address space.
  assign offset   = AddrWidth'(iss_q) << BeatShift;
  assign done_o   = done_q;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    write_d       = write_q;
    iss_d         = iss_q;
    rsp_d         = rsp_q;
    done_d        = 1'b0;
    cmd_ready_o   = 1'b0;
    req_valid_o   = 1'b0;
    req_addr_o    = '0;
    req_we_o      = 1'b0;
    req_wdata_o   = '0;
    wdata_ready_o = 1'b0;
    busy_o        = 1'b0;
    req_hs        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          base_d  = cmd_addr_i;
          len_d   = cmd_len_i;
          write_d = cmd_write_i;
          iss_d   = '0;
          rsp_d   = '0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        busy_o     = 1'b1;
        req_addr_o = base_q + offset;
        req_we_o   = write_q;
        if (write_q) begin
          // Ready towards the data source follows the sink only, never wdata_valid_i, so data
          // moves exactly on the request handshake without a valid->ready loop.
          req_valid_o   = wdata_valid_i;
          wdata_ready_o = req_ready_i;
          req_wdata_o   = wdata_i;
        end else begin
          req_valid_o = 1'b1;
        end
        req_hs = req_valid_o & req_ready_i;
        rsp_d  = rsp_next;
        if (req_hs) begin
          iss_d = iss_q + CntWidth'(1);
          if (iss_q == CntWidth'(len_q)) begin
            if (all_rsp) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end

      StDrain: begin
        busy_o = 1'b1;
        rsp_d  = rsp_next;
        if (all_rsp) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      iss_q   <= '0;
      rsp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      write_q <= write_d;
      iss_q   <= iss_d;
      rsp_q   <= rsp_d;
      done_q  <= done_d;
    end
  end

  // Protocol checks: no responses while idle, never more responses than issued requests.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(state_q == StIdle && rsp_hs_i))
        else $error("mem_burst_req_gen: rsp_hs_i while idle");
      assert (state_q == StIdle || rsp_next <= iss_q + CntWidth'(req_hs))
        else $error("mem_burst_req_gen: response count exceeds issued count");
    end
  end

endmodule

// File: tb/tb_mem_burst_req_gen.sv
// Bench for mem_burst_req_gen: table of bursts plus hand-written reset and back-to-back
// sequences. Expected requests go into a scoreboard queue when a command is driven and are popped
// on each request handshake.
module tb_mem_burst_req_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        cmd_write_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] wdata_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic [31:0] req_addr_o;
  logic        req_we_o;
  logic [31:0] req_wdata_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        rsp_hs_i;
  logic        busy_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  mem_burst_req_gen #(
    .AddrWidth(32),
    .DataWidth(32),
    .LenWidth (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .cmd_write_i  (cmd_write_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .wdata_i      (wdata_i),
    .wdata_valid_i(wdata_valid_i),
    .wdata_ready_o(wdata_ready_o),
    .req_addr_o   (req_addr_o),
    .req_we_o     (req_we_o),
    .req_wdata_o  (req_wdata_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .rsp_hs_i     (rsp_hs_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    bit          write;
    int          lat;       // 0: response in request cycle, 1: one cycle later
    bit          stall;     // random req_ready_i / wdata_valid_i gaps
    logic [31:0] seed;
    logic [31:0] exp_last;  // address of the final beat
    int          exp_busy;  // busy cycles, -1 = don't care
  } vec_t;

  req_t        exp_q[$];
  logic [31:0] wq[$];
  vec_t        tv[6];

  int total = 0;
  int bad   = 0;

  // Drive-side state
  logic [31:0] drv_addr;
  logic [7:0]  drv_len;
  bit          drv_write;
  bit          drv_valid;
  int          lat;
  bit          stall;
  int          pend;
  bit          holding;

  // Reference model state
  bit          active, busy_exp, done_exp, accepted, completed;
  int          beats, hs_cnt, rsp_cnt, busy_cycles, comp_cnt;
  bit          prev_stall;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  logic [31:0] last_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] seed, input int k);
    logic [31:0] d;
    d = k[0] ? ~seed : seed;
    return d ^ 32'(k >> 1);
  endfunction

  task automatic push_burst(input logic [31:0] addr, input logic [7:0] len, input bit write,
                            input logic [31:0] seed);
    req_t r;
    for (int k = 0; k <= int'(len); k++) begin
      r.addr = addr + 32'(k << 2);
      r.we   = write;
      r.data = write ? word(seed, k) : 32'h0;
      exp_q.push_back(r);
      if (write) wq.push_back(word(seed, k));
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    wq.delete();
    pend       = 0;
    holding    = 0;
    active     = 0;
    busy_exp   = 0;
    done_exp   = 0;
    prev_stall = 0;
    drv_valid  = 0;
  endtask

  // One clock cycle: drive at negedge, sample before the next posedge, update the model.
  task automatic step();
    bit   hs, xfer;
    req_t e;
    @(negedge clk_i);
    cmd_addr_i  = drv_addr;
    cmd_len_i   = drv_len;
    cmd_write_i = drv_write;
    cmd_valid_i = drv_valid;
    req_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!holding) begin
      if (wq.size() > 0) begin
        wdata_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wdata_i       = wq[0];
      end else begin
        wdata_valid_i = 1'b0;
      end
    end
    rsp_hs_i = 1'b0;
    if (lat == 1 && pend > 0) begin
      rsp_hs_i = 1'b1;
      pend--;
    end
    #1;
    hs = req_valid_o & req_ready_i;
    if (lat == 0) begin
      rsp_hs_i = hs;
      #1;
    end

    chk("cmd_ready", cmd_ready_o, !busy_exp);
    chk("busy", busy_o, busy_exp);
    chk("done", done_o, done_exp);
    if (prev_stall) begin
      chk("hold_valid", req_valid_o, 1'b1);
      chk("hold_addr", req_addr_o, prev_addr);
      chk("hold_we", req_we_o, prev_we);
      chk("hold_wdata", req_wdata_o, prev_wdata);
    end
    xfer = wdata_valid_i & wdata_ready_o;
    chk("wdata_xfer", xfer, hs & req_we_o);
    if (hs) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got addr %0h want no request", req_addr_o);
      end else begin
        e = exp_q.pop_front();
        chk("req_addr", req_addr_o, e.addr);
        chk("req_we", req_we_o, e.we);
        chk("req_wdata", req_wdata_o, e.data);
      end
      last_addr = req_addr_o;
    end
    if (xfer && wq.size() > 0) void'(wq.pop_front());
    holding    = wdata_valid_i & !xfer;
    prev_stall = req_valid_o & !req_ready_i;
    prev_addr  = req_addr_o;
    prev_we    = req_we_o;
    prev_wdata = req_wdata_o;

    if (lat == 1 && hs) pend++;
    if (busy_o) busy_cycles++;
    done_exp = 0;
    if (active) begin
      hs_cnt  += int'(hs);
      rsp_cnt += int'(rsp_hs_i);
      if (hs_cnt == beats && rsp_cnt == beats) begin
        active    = 0;
        busy_exp  = 0;
        done_exp  = 1;
        completed = 1;
        comp_cnt++;
      end
    end
    if (cmd_valid_i && cmd_ready_o) begin
      accepted = 1;
      active   = 1;
      busy_exp = 1;
      beats    = int'(cmd_len_i) + 1;
      hs_cnt   = 0;
      rsp_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i         = 1'b1;
    cmd_valid_i   = 1'b0;
    req_ready_i   = 1'b0;
    rsp_hs_i      = 1'b0;
    wdata_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_model();
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_wdata_ready", wdata_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_req_addr", req_addr_o, 32'h0);
    chk("rst_req_we", req_we_o, 1'b0);
  endtask

  task automatic run_burst(input vec_t v);
    int n;
    lat         = v.lat;
    stall       = v.stall;
    push_burst(v.addr, v.len, v.write, v.seed);
    drv_addr    = v.addr;
    drv_len     = v.len;
    drv_write   = v.write;
    drv_valid   = 1;
    accepted    = 0;
    completed   = 0;
    busy_cycles = 0;
    n           = 0;
    while (!completed && n < 4000) begin
      step();
      if (accepted) drv_valid = 0;
      n++;
    end
    if (!completed) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: got %0d beats want %0d", hs_cnt, beats);
      clear_model();
    end
    step();  // done_o cycle
    if (v.exp_busy >= 0) chk("busy_cycles", 64'(busy_cycles), 64'(v.exp_busy));
    chk("last_addr", last_addr, v.exp_last);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, base_comp;
    bit   d_before, sw;
    vec_t v;

    tv[0] = '{32'h0000_0100, 8'd3,   1'b0, 1, 1'b0, 32'h0,         32'h0000_010C, 5};
    tv[1] = '{32'h0000_2000, 8'd1,   1'b1, 1, 1'b1, 32'hA5A5_A5A5, 32'h0000_2004, -1};
    tv[2] = '{32'h0000_0040, 8'd0,   1'b0, 0, 1'b0, 32'h0,         32'h0000_0040, 1};
    tv[3] = '{32'hFFFF_FFF8, 8'd255, 1'b0, 1, 1'b0, 32'h0,         32'h0000_03F4, 257};
    tv[4] = '{32'h0000_3000, 8'd7,   1'b1, 0, 1'b1, 32'h1234_5678, 32'h0000_301C, -1};
    tv[5] = '{32'h0000_0FFC, 8'd2,   1'b0, 1, 1'b1, 32'h0,         32'h0000_1004, -1};

    drv_addr  = '0;
    drv_len   = '0;
    drv_write = 0;
    lat       = 1;
    stall     = 0;
    comp_cnt  = 0;
    wdata_i   = '0;
    cmd_addr_i = '0;
    cmd_len_i  = '0;
    cmd_write_i = 1'b0;
    rst_i     = 1'b1;
    do_reset();

    for (int i = 0; i < 6; i++) run_burst(tv[i]);

    // Reset after 2 of 4 beats: burst is dropped silently, then a fresh burst starts clean.
    lat   = 1;
    stall = 0;
    push_burst(32'h0000_0500, 8'd3, 1'b0, 32'h0);
    drv_addr  = 32'h0000_0500;
    drv_len   = 8'd3;
    drv_write = 0;
    drv_valid = 1;
    accepted  = 0;
    n         = 0;
    while (!(active && hs_cnt == 2) && n < 50) begin
      step();
      if (accepted) drv_valid = 0;
      n++;
    end
    chk("mid_beats", 64'(hs_cnt), 64'd2);
    do_reset();
    for (int i = 0; i < 3; i++) step();
    v = '{32'h0000_0600, 8'd1, 1'b0, 1, 1'b0, 32'h0, 32'h0000_0604, 3};
    run_burst(v);

    // Back-to-back: cmd_valid stays high, second command must go in on the done_o cycle.
    lat   = 1;
    stall = 0;
    push_burst(32'h0000_0700, 8'd1, 1'b0, 32'h0);
    push_burst(32'h0000_0800, 8'd0, 1'b0, 32'h0);
    drv_addr  = 32'h0000_0700;
    drv_len   = 8'd1;
    drv_write = 0;
    drv_valid = 1;
    accepted  = 0;
    sw        = 0;
    base_comp = comp_cnt;
    n         = 0;
    while (comp_cnt < base_comp + 2 && n < 200) begin
      d_before = done_exp;
      step();
      if (accepted) begin
        accepted = 0;
        if (!sw) begin
          drv_addr = 32'h0000_0800;
          drv_len  = 8'd0;
          sw       = 1;
        end else begin
          drv_valid = 0;
          chk("b2b_accept_in_done", d_before, 1'b1);
        end
      end
      n++;
    end
    chk("b2b_completions", 64'(comp_cnt - base_comp), 64'd2);
    step();
    chk("b2b_last_addr", last_addr, 32'h0000_0800);
    chk("b2b_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
